lock_key_sequencer: RTL

- Key-delivery side of the time-phased locked FSM benchmarks. The locked FSM checks a different key in each window of its free-running negedge phase counter.
- This block stores NUM_KEYS key words, loaded through a valid/ready port. It mirrors the consumer's phase counter and drives the correct key on key_out for each window.
- Sits beside the locked core in the test harness. Its key_out connects directly to keyinput0..keyinputN (bit 0 = keyinput0).

---
 rtl/lock_key_sequencer_if.sv | 24 ++
 rtl/lock_key_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lock_key_sequencer_if.sv
// Key-load bus for lock_key_sequencer: valid/ready word
// transfer, master = key source, slave = sequencer.
interface lock_key_sequencer_if #(
  parameter int KEY_W = 5
);
  logic             load_valid;
  logic             load_ready;
  logic [KEY_W-1:0] load_data;
  logic             load_last;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/lock_key_sequencer.sv
// Key schedule driver for a time-phased locked FSM: stores
// NUM_KEYS key words and presents key[phase/HOLD] on key_out.
// Ports: clk, rst (async, active-high), clr (sync clear),
//   ld (load bus slave: valid/ready/data/last), arm (run level),
//   key_out/key_valid (registered key), phase (negedge mirror
//   of the consumer counter), err (sticky load error).
// Option: KEYSEQ_ZEROIZE_EN clears keys on error, clr, de-arm.
module lock_key_sequencer #(
  parameter  int KEY_W    = 5,
  parameter  int NUM_KEYS = 2,
  parameter  int HOLD     = 2,
  localparam int P        = NUM_KEYS * HOLD,
  localparam int PH_W     = (P > 1) ? $clog2(P) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  lock_key_sequencer_if.slave ld,
  input  logic             arm,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic [PH_W-1:0]  phase,
  output logic             err
);

`ifdef KEYSEQ_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  localparam int IDX_W = $clog2(NUM_KEYS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_KEYS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, READY, RUN, ERROR
  } state_t;

  state_t           st_q, st_d;
  logic [IDX_W-1:0] idx_q, idx_d, widx;
  logic             we, zero, hs;
  logic [KEY_W-1:0] key_q [NUM_KEYS];
  logic [PH_W-1:0]  phase_q;
  logic [KEY_W-1:0] act_key;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic             kv_q, kv_d;

  // Free-running so it tracks a consumer reset by the same rst.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)
      phase_q <= '0;
    else if (phase_q >= PH_W'(P - 1))
      phase_q <= '0;
    else
      phase_q <= phase_q + 1'b1;
  end

  // No word is taken while clr wins or arm moves READY to RUN.
  assign ld.load_ready = !rst && !clr &&
    (st_q == IDLE || st_q == LOAD ||
     (st_q == READY && !arm));

  assign hs = ld.load_valid && ld.load_ready;

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    we    = 1'b0;
    widx  = idx_q;
    zero  = 1'b0;
    if (clr) begin
      st_d  = IDLE;
      idx_d = '0;
      zero  = ZEROIZE;
    end else begin
      unique case (st_q)
        IDLE, READY: begin
          if (st_q == READY && arm) begin
            st_d = RUN;
          end else if (hs) begin
            if (ld.load_last && NUM_KEYS > 1) begin
              st_d = ERROR;
              zero = ZEROIZE;
            end else begin
              we    = 1'b1;
              widx  = '0;
              idx_d = IDX_W'(1);
              st_d  = ld.load_last ? READY : LOAD;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            if (ld.load_last == (idx_q == LAST_IDX) &&
                idx_q <= LAST_IDX) begin
              we    = 1'b1;
              idx_d = idx_q + 1'b1;
              if (ld.load_last)
                st_d = READY;
            end else begin
              st_d = ERROR;
              zero = ZEROIZE;
            end
          end
        end
        RUN: begin
          if (!arm) begin
            st_d = READY;
            zero = ZEROIZE;
          end
        end
        ERROR: begin
          st_d = ERROR;
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      idx_q <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++)
        key_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (zero)
          key_q[i] <= '0;
        else if (we && widx == IDX_W'(i))
          key_q[i] <= ld.load_data;
      end
    end
  end

  // Window index k = phase / HOLD.
  always_comb begin
    act_key = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (32'(phase_q) / 32'(HOLD) == 32'(i))
        act_key = key_q[i];
    end
  end

  always_comb begin
    kv_d      = (st_q == RUN);
    key_out_d = kv_d ? act_key : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_out_q <= '0;
      kv_q      <= 1'b0;
    end else begin
      key_out_q <= key_out_d;
      kv_q      <= kv_d;
    end
  end

  assign key_out   = key_out_q;
  assign key_valid = kv_q;
  assign phase     = phase_q;
  assign err       = (st_q == ERROR);

endmodule
